tx_cpl_engine: RTL and testbench
================================

TX_CPL_ENGINE -- requirements
Module: tx_cpl_engine

Interface
REQ-001 Parameter C_DATA_WIDTH, default 64, TX AXI-S data width; only 64 is supported.
REQ-002 clk_i  in  1  250 MHz PCIe user clock; the only clock.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 s_axis_tx_tdata  out  64  TLP beat; s_axis_tx_tkeep  out  8  byte enables.
REQ-005 s_axis_tx_tvalid / s_axis_tx_tlast  out  1 each; s_axis_tx_tready  in  1  core ready.
REQ-006 cfg_completer_id_i  in  16  bus/dev/func used as the Completer ID.
REQ-007 req_compl_wd_i  in  1  level request, held until compl_done_o, for a 1DW CplD.
REQ-008 tx_reg_data_i  in  32; req_tc_i  in  3; req_td_i, req_ep_i  in  1; req_attr_i  in  2; req_rid_i  in  16; req_tag_i  in  8; req_addr_i  in  7: completion fields.
REQ-009 compl_done_o  out  1  one-cycle pulse when the CplD has been fully accepted.
REQ-010 rd_req_i  in  1  level DMA MRd32 request; rd_addr_i  in  32 (DW aligned); rd_len_i  in  10 (DW, 0 = 1024).
REQ-011 rd_req_ack_o  out  1  one-cycle pulse when the MRd is fully accepted; rd_tag_o  out  8  tag used by that MRd.

Function
REQ-012 FSM states: IDLE, CPL_B0, CPL_B1, CPL_DONE, RD_B0, RD_B1, RD_DONE.
REQ-013 IDLE: if req_compl_wd_i, latch all completion inputs and go to CPL_B0; else if rd_req_i, latch rd_addr_i/rd_len_i and go to RD_B0; completion has fixed priority over read.
REQ-014 Beat 0 is valid the cycle after the IDLE decision (1-cycle latency); all AXI-S outputs are registered.
REQ-015 A beat advances only on tvalid && tready; while tready is low, tdata/tkeep/tlast are held unchanged.
REQ-016 CplD DW0 = {1'b0, fmt 2'b10, type 5'b01010, 1'b0, tc, 4'b0, td, ep, attr, 2'b0, length 10'd1}.
REQ-017 CplD DW1 = {completer ID, status 3'b000, BCM 1'b0, byte count 12'd4}; DW2 = {requester ID, tag, 1'b0, req_addr[6:0]}.
REQ-018 CplD beat0 tdata = {DW1, DW0}, tkeep 8'hFF, tlast 0; beat1 tdata = {data, DW2}, tkeep 8'hFF, tlast 1.
REQ-019 MRd DW0 = {1'b0, fmt 2'b00, type 5'b00000, 1'b0, tc 3'b0, 4'b0, td 0, ep 0, attr 2'b0, 2'b0, rd_len}; DW1 = {completer ID, tag, last BE 4'hF (4'h0 when rd_len = 1), first BE 4'hF}.
REQ-020 MRd beat0 = {DW1, DW0}, tkeep 8'hFF; beat1 = {32'h0, rd_addr[31:2], 2'b00}, tkeep 8'h0F, tlast 1.
REQ-021 CPL_DONE / RD_DONE last exactly one cycle, pulse compl_done_o / rd_req_ack_o, then return to IDLE; no new request is sampled in that cycle.
REQ-022 8-bit tag counter starts at 0, is driven on rd_tag_o, increments by 1 on each rd_req_ack_o, and wraps from 8'hFF to 8'h00.
REQ-023 A simultaneous req_compl_wd_i and rd_req_i send the CplD first; the read is then sent from IDLE after CPL_DONE.
REQ-024 A request that deasserts mid-packet does not abort it; the latched packet completes.

Reset
REQ-025 On rst_n low: state IDLE, tvalid 0, tlast 0, tkeep 0, tdata 0, compl_done_o 0, rd_req_ack_o 0, tag counter 0, latched fields 0.
REQ-026 Reset asserted mid-packet drops tvalid immediately; the partial TLP is abandoned and no done/ack pulse is issued.

Structure
REQ-027 TLP fmt/type encodings, status codes and FSM state constants are defined in a shared pcie_tlp_pkg, which rx-side blocks also use.
REQ-028 Single module; no sub-module; header assembly is combinational from latched fields into the registered beat outputs.

Verification
REQ-029 CplD with tready=1, tc=0, attr=0, rid=16'h0100, tag=8'h05, addr=7'h10, data=32'hDEADBEEF, cpl id=16'h0200 -> beat0 = 64'h02000004_4A000001; beat1 = 64'hDEADBEEF_01000510; compl_done_o pulses 1 cycle after beat1.
REQ-030 Same CplD with tready low for 3 cycles during beat0 -> beat0 held stable, exactly 2 beats accepted, single compl_done_o.
REQ-031 MRd with rd_addr=32'h1000_0040, rd_len=10'd32 -> beat0 DW0 = 32'h00000020, DW1 tag=8'h00, BE=8'hFF; beat1 = 64'h00000000_10000040 with tkeep 8'h0F; rd_tag_o becomes 8'h01.
REQ-032 Both requests asserted in the same cycle -> CplD is emitted first, MRd follows, with no gap longer than 2 idle cycles.
REQ-033 256 back-to-back MRds -> tags 0x00 through 0xFF, then 0x00 again.
REQ-034 rst_n pulsed low during CplD beat1 with tready low -> tvalid 0 asynchronously, no compl_done_o, clean CplD on the next request.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP encodings, FSM state constants and header builders for the
// 64-bit TX/RX user-side engines.
package pcie_tlp_pkg;

    localparam int unsigned TLP_DATA_W = 64;
    localparam int unsigned TLP_KEEP_W = TLP_DATA_W / 8;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
    localparam logic [4:0] TYPE_MRD       = 5'b00000;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;
    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_CPL_B0   = 3'd1;
    localparam logic [ST_W-1:0] ST_CPL_B1   = 3'd2;
    localparam logic [ST_W-1:0] ST_CPL_DONE = 3'd3;
    localparam logic [ST_W-1:0] ST_RD_B0    = 3'd4;
    localparam logic [ST_W-1:0] ST_RD_B1    = 3'd5;
    localparam logic [ST_W-1:0] ST_RD_DONE  = 3'd6;

    // Fields captured from the requester for a 1DW completion with data.
    typedef struct packed {
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [6:0]  addr;
        logic [31:0] data;
    } cpl_req_t;

    function automatic logic [TLP_DATA_W-1:0] cpld_beat0(input logic [15:0] cid,
                                                         input cpl_req_t  r);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {1'b0, FMT_3DW_DATA, TYPE_CPL, 1'b0, r.tc, 4'b0, r.td, r.ep, r.attr,
               2'b0, 10'd1};
        dw1 = {cid, CPL_STATUS_SC, 1'b0, 12'd4};
        return {dw1, dw0};
    endfunction

    function automatic logic [TLP_DATA_W-1:0] cpld_beat1(input cpl_req_t r);
        logic [31:0] dw2;
        dw2 = {r.rid, r.tag, 1'b0, r.addr};
        return {r.data, dw2};
    endfunction

    function automatic logic [TLP_DATA_W-1:0] mrd_beat0(input logic [15:0] cid,
                                                        input logic [7:0]  tag,
                                                        input logic [9:0]  len);
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [3:0]  last_be;
        last_be = (len == 10'd1) ? 4'h0 : 4'hF;
        dw0 = {1'b0, FMT_3DW_NODATA, TYPE_MRD, 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b0,
               2'b0, len};
        dw1 = {cid, tag, last_be, 4'hF};
        return {dw1, dw0};
    endfunction

    function automatic logic [TLP_DATA_W-1:0] mrd_beat1(input logic [31:0] addr);
        return {32'h0, addr & 32'hFFFF_FFFC};
    endfunction

endpackage

// File: rtl/tx_cpl_engine.sv
// TX engine: emits 1DW CplD completions and DMA MRd32 requests as two-beat
// 64-bit AXI-Stream TLPs, completion taking priority over reads.
module tx_cpl_engine
    import pcie_tlp_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
    output logic                      s_axis_tx_tvalid,
    output logic                      s_axis_tx_tlast,
    input  logic                      s_axis_tx_tready,
    input  logic [15:0]               cfg_completer_id_i,
    input  logic                      req_compl_wd_i,
    input  logic [31:0]               tx_reg_data_i,
    input  logic [2:0]                req_tc_i,
    input  logic                      req_td_i,
    input  logic                      req_ep_i,
    input  logic [1:0]                req_attr_i,
    input  logic [15:0]               req_rid_i,
    input  logic [7:0]                req_tag_i,
    input  logic [6:0]                req_addr_i,
    output logic                      compl_done_o,
    input  logic                      rd_req_i,
    input  logic [31:0]               rd_addr_i,
    input  logic [9:0]                rd_len_i,
    output logic                      rd_req_ack_o,
    output logic [7:0]                rd_tag_o
);

    localparam int unsigned KEEP_W = C_DATA_WIDTH / 8;

    logic [ST_W-1:0]         state_q, state_d;
    logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0]       tkeep_q, tkeep_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    done_q, done_d;
    logic                    ack_q, ack_d;
    logic [7:0]              tag_q, tag_d;
    cpl_req_t                cpl_q, cpl_d;
    logic [15:0]             cid_q, cid_d;
    logic [31:0]             rd_addr_q, rd_addr_d;
    logic [9:0]              rd_len_q, rd_len_d;

    logic                    beat_acc;

    assign beat_acc = tvalid_q && s_axis_tx_tready;

    // Next-state, latched-field and registered-beat logic.
    always_comb begin
        state_d   = state_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        done_d    = 1'b0;
        ack_d     = 1'b0;
        tag_d     = tag_q;
        cpl_d     = cpl_q;
        cid_d     = cid_q;
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;

        case (state_q)
            ST_IDLE: begin
                if (req_compl_wd_i) begin
                    cpl_d    = '{tc: req_tc_i, td: req_td_i, ep: req_ep_i,
                                 attr: req_attr_i, rid: req_rid_i, tag: req_tag_i,
                                 addr: req_addr_i, data: tx_reg_data_i};
                    cid_d    = cfg_completer_id_i;
                    tdata_d  = cpld_beat0(cid_d, cpl_d);
                    tkeep_d  = KEEP_W'('1);
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b1;
                    state_d  = ST_CPL_B0;
                end else if (rd_req_i) begin
                    rd_addr_d = rd_addr_i;
                    rd_len_d  = rd_len_i;
                    cid_d     = cfg_completer_id_i;
                    tdata_d   = mrd_beat0(cid_d, tag_q, rd_len_d);
                    tkeep_d   = KEEP_W'('1);
                    tlast_d   = 1'b0;
                    tvalid_d  = 1'b1;
                    state_d   = ST_RD_B0;
                end
            end
            ST_CPL_B0: begin
                if (beat_acc) begin
                    tdata_d = cpld_beat1(cpl_q);
                    tlast_d = 1'b1;
                    state_d = ST_CPL_B1;
                end
            end
            ST_CPL_B1: begin
                if (beat_acc) begin
                    tdata_d  = '0;
                    tkeep_d  = '0;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_CPL_DONE;
                end
            end
            ST_CPL_DONE: state_d = ST_IDLE;
            ST_RD_B0: begin
                if (beat_acc) begin
                    tdata_d = mrd_beat1(rd_addr_q);
                    tkeep_d = KEEP_W'(8'h0F);
                    tlast_d = 1'b1;
                    state_d = ST_RD_B1;
                end
            end
            ST_RD_B1: begin
                if (beat_acc) begin
                    tdata_d  = '0;
                    tkeep_d  = '0;
                    tlast_d  = 1'b0;
                    tvalid_d = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = ST_RD_DONE;
                end
            end
            ST_RD_DONE: begin
                // Tag advances after the ack so rd_tag_o names the acked MRd during the pulse.
                tag_d   = tag_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: begin
                tvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            tag_q     <= '0;
            cpl_q     <= '0;
            cid_q     <= '0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            tag_q     <= tag_d;
            cpl_q     <= cpl_d;
            cid_q     <= cid_d;
            rd_addr_q <= rd_addr_d;
            rd_len_q  <= rd_len_d;
        end
    end

    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tvalid = tvalid_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign compl_done_o     = done_q;
    assign rd_req_ack_o     = ack_q;
    assign rd_tag_o         = tag_q;

endmodule

// File: tb/tb_tx_cpl_engine.sv
// Scoreboard bench for tx_cpl_engine: expected beats are queued at request
// time and compared as the core accepts them.
module tb_tx_cpl_engine;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk_i;
    logic        rst_n;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tready;
    logic [15:0] cfg_completer_id_i;
    logic        req_compl_wd_i;
    logic [31:0] tx_reg_data_i;
    logic [2:0]  req_tc_i;
    logic        req_td_i;
    logic        req_ep_i;
    logic [1:0]  req_attr_i;
    logic [15:0] req_rid_i;
    logic [7:0]  req_tag_i;
    logic [6:0]  req_addr_i;
    logic        compl_done_o;
    logic        rd_req_i;
    logic [31:0] rd_addr_i;
    logic [9:0]  rd_len_i;
    logic        rd_req_ack_o;
    logic [7:0]  rd_tag_o;

    tx_cpl_engine #(.C_DATA_WIDTH(64)) dut (
        .clk_i              (clk_i),
        .rst_n              (rst_n),
        .s_axis_tx_tdata    (s_axis_tx_tdata),
        .s_axis_tx_tkeep    (s_axis_tx_tkeep),
        .s_axis_tx_tvalid   (s_axis_tx_tvalid),
        .s_axis_tx_tlast    (s_axis_tx_tlast),
        .s_axis_tx_tready   (s_axis_tx_tready),
        .cfg_completer_id_i (cfg_completer_id_i),
        .req_compl_wd_i     (req_compl_wd_i),
        .tx_reg_data_i      (tx_reg_data_i),
        .req_tc_i           (req_tc_i),
        .req_td_i           (req_td_i),
        .req_ep_i           (req_ep_i),
        .req_attr_i         (req_attr_i),
        .req_rid_i          (req_rid_i),
        .req_tag_i          (req_tag_i),
        .req_addr_i         (req_addr_i),
        .compl_done_o       (compl_done_o),
        .rd_req_i           (rd_req_i),
        .rd_addr_i          (rd_addr_i),
        .rd_len_i           (rd_len_i),
        .rd_req_ack_o       (rd_req_ack_o),
        .rd_tag_o           (rd_tag_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    beat_t       exp_q[$];
    beat_t       eb;
    logic [7:0]  next_tag = 8'h00;
    logic [7:0]  ack_tag  = 8'h00;
    int          cpl_cnt  = 0;
    int          ack_cnt  = 0;
    int          rdy_mode = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    initial begin
        clk_i = 1'b0;
        forever #2 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // tready driver: 0 = always ready, 1 = random backpressure, 2 = test-driven
    always @(posedge clk_i) begin
        #1;
        if (rdy_mode == 0) s_axis_tx_tready = 1'b1;
        else if (rdy_mode == 1) s_axis_tx_tready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk_i) begin
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            if (exp_q.size() == 0) chk("beat_unexpected", 64'(exp_q.size()), 64'd1);
            else begin
                eb = exp_q.pop_front();
                chk("tdata", s_axis_tx_tdata, eb.d);
                chk("tkeep", 64'(s_axis_tx_tkeep), 64'(eb.k));
                chk("tlast", 64'(s_axis_tx_tlast), 64'(eb.l));
            end
        end
        if (prev_stall && s_axis_tx_tvalid) begin
            chk("hold_tdata", s_axis_tx_tdata, prev_data);
            chk("hold_tkeep", 64'(s_axis_tx_tkeep), 64'(prev_keep));
            chk("hold_tlast", 64'(s_axis_tx_tlast), 64'(prev_last));
        end
        prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
        prev_data  = s_axis_tx_tdata;
        prev_keep  = s_axis_tx_tkeep;
        prev_last  = s_axis_tx_tlast;
        if (compl_done_o) cpl_cnt++;
        if (rd_req_ack_o) begin
            chk("ack_tag", 64'(rd_tag_o), 64'(ack_tag));
            ack_tag = ack_tag + 8'd1;
            ack_cnt++;
        end
    end

    task automatic set_cpl(input logic [15:0] cid, input logic [2:0] tc, input logic td,
                           input logic ep, input logic [1:0] attr, input logic [15:0] rid,
                           input logic [7:0] tg, input logic [6:0] ad, input logic [31:0] dat);
        cfg_completer_id_i = cid;
        req_tc_i = tc;   req_td_i  = td;  req_ep_i   = ep; req_attr_i = attr;
        req_rid_i = rid; req_tag_i = tg;  req_addr_i = ad; tx_reg_data_i = dat;
    endtask

    // Reference CplD beats built from the current request inputs.
    task automatic push_cpl();
        exp_q.push_back('{d: {cfg_completer_id_i, 16'h0004, 8'h4A, 1'b0, req_tc_i, 4'h0,
                              req_td_i, req_ep_i, req_attr_i, 2'b00, 10'd1},
                          k: 8'hFF, l: 1'b0});
        exp_q.push_back('{d: {tx_reg_data_i, req_rid_i, req_tag_i, 1'b0, req_addr_i},
                          k: 8'hFF, l: 1'b1});
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [9:0] l);
        logic [7:0] be;
        be = (l == 10'd1) ? 8'h0F : 8'hFF;
        exp_q.push_back('{d: {cfg_completer_id_i, next_tag, be, 22'h0, l}, k: 8'hFF, l: 1'b0});
        exp_q.push_back('{d: {32'h0, a[31:2], 2'b00}, k: 8'h0F, l: 1'b1});
        next_tag = next_tag + 8'd1;
    endtask

    task automatic send_cpl(output int waited);
        int c0;
        bit seen;
        c0 = cpl_cnt;
        req_compl_wd_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("cpl_beat0_latency", 64'(s_axis_tx_tvalid), 64'd1);
        seen = 0;
        waited = 0;
        while (!seen && waited < 200) begin
            @(negedge clk_i);
            if (compl_done_o) seen = 1;
            else waited++;
        end
        req_compl_wd_i = 1'b0;
        chk("cpl_done_seen", 64'(seen), 64'd1);
        @(posedge clk_i);
        #1;
        chk("cpl_done_count", 64'(cpl_cnt - c0), 64'd1);
        chk("cpl_done_width", 64'(compl_done_o), 64'd0);
        chk("cpl_beats_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_rd(input logic [31:0] a, input logic [9:0] l, output int waited);
        int c0;
        bit seen;
        c0 = ack_cnt;
        rd_addr_i = a;
        rd_len_i  = l;
        push_rd(a, l);
        rd_req_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rd_beat0_latency", 64'(s_axis_tx_tvalid), 64'd1);
        seen = 0;
        waited = 0;
        while (!seen && waited < 200) begin
            @(negedge clk_i);
            if (rd_req_ack_o) seen = 1;
            else waited++;
        end
        rd_req_i = 1'b0;
        chk("rd_ack_seen", 64'(seen), 64'd1);
        @(posedge clk_i);
        #1;
        chk("rd_ack_count", 64'(ack_cnt - c0), 64'd1);
        chk("rd_ack_width", 64'(rd_req_ack_o), 64'd0);
        chk("rd_tag_next", 64'(rd_tag_o), 64'(next_tag));
        chk("rd_beats_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int  w;
        int  c0;
        int  gap;
        bit  seen;
        bit  got;

        rst_n = 1'b0;
        s_axis_tx_tready = 1'b1;
        req_compl_wd_i = 1'b0;
        rd_req_i = 1'b0;
        rd_addr_i = '0;
        rd_len_i = '0;
        set_cpl(16'h0200, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0, 8'h0, 7'h0, 32'h0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
        chk("rst_tlast", 64'(s_axis_tx_tlast), 64'd0);
        chk("rst_tkeep", 64'(s_axis_tx_tkeep), 64'd0);
        chk("rst_tdata", s_axis_tx_tdata, 64'd0);
        chk("rst_done", 64'(compl_done_o), 64'd0);
        chk("rst_ack", 64'(rd_req_ack_o), 64'd0);
        chk("rst_tag", 64'(rd_tag_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;

        // Reference CplD with literal expected beats
        set_cpl(16'h0200, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h05, 7'h10, 32'hDEADBEEF);
        exp_q.push_back('{d: 64'h02000004_4A000001, k: 8'hFF, l: 1'b0});
        exp_q.push_back('{d: 64'hDEADBEEF_01000510, k: 8'hFF, l: 1'b1});
        send_cpl(w);
        chk("cpl_done_delay", 64'(w), 64'd1);

        // Same CplD with tready low for 3 cycles on beat0
        rdy_mode = 2;
        s_axis_tx_tready = 1'b0;
        push_cpl();
        c0 = cpl_cnt;
        req_compl_wd_i = 1'b1;
        @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
        chk("stall_beat0_valid", 64'(s_axis_tx_tvalid), 64'd1);
        chk("stall_beat0_data", s_axis_tx_tdata, 64'h02000004_4A000001);
        chk("stall_beats_pending", 64'(exp_q.size()), 64'd2);
        s_axis_tx_tready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (compl_done_o) seen = 1;
        end
        req_compl_wd_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("stall_done_seen", 64'(seen), 64'd1);
        chk("stall_done_count", 64'(cpl_cnt - c0), 64'd1);
        chk("stall_beats_left", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;

        // Reference MRd
        cfg_completer_id_i = 16'h0200;
        send_rd(32'h1000_0040, 10'd32, w);
        chk("rd_tag_after_first", 64'(rd_tag_o), 64'h01);

        // Length corner cases: 1 DW (last BE zero) and 1024 DW (encoded as 0)
        send_rd(32'h2000_0004, 10'd1, w);
        send_rd(32'hFFFF_FFFC, 10'd0, w);

        // Randomised CplDs under backpressure
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            set_cpl(16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                    16'($urandom), 8'($urandom), 7'($urandom), 32'($urandom));
            push_cpl();
            send_cpl(w);
        end
        rdy_mode = 0;

        // Simultaneous requests: CplD first, MRd afterwards with a short gap
        set_cpl(16'h0300, 3'd5, 1'b1, 1'b0, 2'd2, 16'hABCD, 8'h7E, 7'h3C, 32'h1234_5678);
        rd_addr_i = 32'h0000_8000;
        rd_len_i  = 10'd4;
        push_cpl();
        push_rd(rd_addr_i, rd_len_i);
        c0 = ack_cnt;
        req_compl_wd_i = 1'b1;
        rd_req_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (compl_done_o) seen = 1;
        end
        req_compl_wd_i = 1'b0;
        chk("simul_cpl_done", 64'(seen), 64'd1);
        chk("simul_cpl_first", 64'(exp_q.size()), 64'd2);
        gap = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (s_axis_tx_tvalid) got = 1;
            else gap++;
        end
        chk("simul_gap_le2", 64'(got && gap <= 2), 64'd1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (rd_req_ack_o) seen = 1;
        end
        rd_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("simul_rd_ack", 64'(ack_cnt - c0), 64'd1);
        chk("simul_beats_left", 64'(exp_q.size()), 64'd0);

        // Back-to-back MRds through a full tag wrap, part of them backpressured
        for (int i = 0; i < 257; i++) begin
            rdy_mode = (i < 128) ? 1 : 0;
            send_rd(32'($urandom) & 32'hFFFF_FFFC, 10'($urandom), w);
        end
        rdy_mode = 0;
        chk("tag_wrapped", 64'(rd_tag_o), 64'(next_tag));

        // Reset during CplD beat1 while stalled
        rdy_mode = 2;
        s_axis_tx_tready = 1'b1;
        set_cpl(16'h0400, 3'd1, 1'b0, 1'b1, 2'd1, 16'h5555, 8'h22, 7'h01, 32'hCAFE_F00D);
        push_cpl();
        c0 = cpl_cnt;
        req_compl_wd_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        s_axis_tx_tready = 1'b0;
        chk("rst_mid_beat1_valid", 64'(s_axis_tx_tvalid), 64'd1);
        chk("rst_mid_beat1_last", 64'(s_axis_tx_tlast), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
        chk("rst_mid_tlast", 64'(s_axis_tx_tlast), 64'd0);
        chk("rst_mid_tdata", s_axis_tx_tdata, 64'd0);
        chk("rst_mid_tag", 64'(rd_tag_o), 64'd0);
        req_compl_wd_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mid_no_done", 64'(cpl_cnt - c0), 64'd0);
        exp_q.delete();
        next_tag = 8'h00;
        ack_tag  = 8'h00;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk_i);
        #1;
        set_cpl(16'h0200, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0100, 8'h05, 7'h10, 32'hDEADBEEF);
        push_cpl();
        send_cpl(w);
        send_rd(32'h1000_0040, 10'd32, w);
        chk("post_rst_tag", 64'(rd_tag_o), 64'h01);

        repeat (3) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
